poly_op_ctrl: RTL and testbench
===============================

Name: poly_op_ctrl

Overview:
Sequencer for the polynomial-arithmetic datapath. It accepts one operation command (NTT, INVNTT, MULT or ADDSUB) and drives the address generator's mode, stage and cycle count through every stage. It also generates read/write enables aligned to the datapath pipeline, and pulses done when the last write-back has completed. It sits between the top-level Kyber FSM and the address generator, butterfly units and coefficient RAM.

Parameters:
PIPE_LAT, 6, read-to-write latency of butterfly datapath in NTT/INVNTT (matches write-address delay line depth)
STAGE_CYC, 32, read cycles per NTT/INVNTT stage
NUM_STAGE, 7, stages per NTT/INVNTT (stage 0..6)
MULT_CYC, 140, total MULT cycles (128 read + 12 pipeline)
ADDSUB_CYC, 68, total ADDSUB cycles (64 read + 4 pipeline)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  command strobe; sampled only in IDLE
op  input  2  0=NTT 1=INVNTT 2=MULT 3=ADDSUB; latched with start
busy  output  1  high from the cycle after an accepted start through the DONE cycle
done  output  1  one-cycle pulse when the operation has completed
mode  output  2  latched op, to address generator
stage  output  3  current stage (NTT/INVNTT); 0 for MULT/ADDSUB
cycle_cnt  output  8  per-stage cycle index, to address generator
rd_en  output  1  RAM read enable
wr_en  output  1  RAM write enable

Behaviour:
- Reset (synchronous, any state, including mid-operation): state=IDLE. busy, done, rd_en, wr_en, stage, cycle_cnt and mode are all 0. The wr_en delay line is cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches op into mode; next state is RUN with cycle_cnt=0 and stage=0.
  - start=0 stays in IDLE; mode holds its last value.
- RUN, NTT/INVNTT:
  - rd_en=1; cycle_cnt increments 0..STAGE_CYC-1.
  - At cycle_cnt=STAGE_CYC-1, go to DRAIN.
- DRAIN (NTT/INVNTT only):
  - rd_en=0; cycle_cnt holds at STAGE_CYC-1; lasts exactly PIPE_LAT cycles (internal counter).
  - After the last drain cycle: if stage=NUM_STAGE-1, go to DONE; otherwise stage+1, cycle_cnt=0, back to RUN.
  - The next stage's first read therefore follows the previous stage's last write by 1 cycle.
- NTT/INVNTT wr_en: rd_en delayed exactly PIPE_LAT cycles through a shift register.
- Stage order: stage counts 0 to 6 ascending in both NTT and INVNTT. The address generator maps stage to butterfly distance.
- RUN, MULT:
  - cycle_cnt runs 0..MULT_CYC-1; stage=0; no DRAIN.
  - rd_en = (cycle_cnt<128); wr_en = (12<=cycle_cnt<140), decoded from cycle_cnt.
  - After cycle_cnt=MULT_CYC-1, go to DONE.
- RUN, ADDSUB:
  - cycle_cnt runs 0..ADDSUB_CYC-1; stage=0.
  - rd_en = (cycle_cnt<64); wr_en = (4<=cycle_cnt<68).
  - After cycle_cnt=ADDSUB_CYC-1, go to DONE.
- DONE: done=1 and busy=1 for one cycle; rd_en=wr_en=0; cycle_cnt and stage reset to 0; next state is IDLE.
- start is ignored in RUN, DRAIN and DONE; there is no queuing. A new command is accepted no earlier than the cycle after DONE.
- op is ignored except in the IDLE cycle where start=1. op changes during an operation have no effect.
- Latency, with start accepted at edge k and RUN beginning at k+1:
  - NTT/INVNTT: done at k+1+7*(32+6) = k+267.
  - MULT: done at k+141.
  - ADDSUB: done at k+69.
- cycle_cnt is an 8-bit counter; it never wraps within an operation (maximum 139).
- All outputs are registered or decoded from registered state only; there are no combinational paths from start or op to outputs.

Test Plan:
- Reset then idle: rst 2 cycles, start=0 -> busy=done=rd_en=wr_en=0, mode=0, cycle_cnt=0, stage=0 held.
- NTT, start at cycle 10 with op=0:
  - busy rises at 11; rd_en high 11..42, low 43..48; stage=1 at 49.
  - wr_en high 17..48.
  - Exactly 7*32=224 rd_en and 224 wr_en cycles; done single pulse at 277; stage sequence 0..6.
- MULT, op=2:
  - rd_en for cycle_cnt 0..127; wr_en for cycle_cnt 12..139; stage stays 0.
  - done 141 cycles after start; 128 writes total.
- ADDSUB, op=3: 64 rd_en and 64 wr_en cycles (wr_en for cycle_cnt 4..67); done 69 cycles after start; mode=3 throughout.
- start and op toggled mid-INVNTT, plus start asserted during the DONE cycle: both ignored; mode stays 1; operation length unchanged; IDLE afterwards.
- rst asserted during NTT stage 3 DRAIN -> next cycle all outputs 0, state IDLE, no stray wr_en. A following ADDSUB start runs normally.

Source files
------------

// File: rtl/poly_op_ctrl.sv
// Sequencer for the polynomial-arithmetic datapath. It steps the address generator through
// NTT/INVNTT stages or a flat MULT/ADDSUB sweep and produces pipeline-aligned RAM enables.
module poly_op_ctrl #(
    parameter int PIPE_LAT   = 6,
    parameter int STAGE_CYC  = 32,
    parameter int NUM_STAGE  = 7,
    parameter int MULT_CYC   = 140,
    parameter int ADDSUB_CYC = 68
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    output logic       busy,
    output logic       done,
    output logic [1:0] mode,
    output logic [2:0] stage,
    output logic [7:0] cycle_cnt,
    output logic       rd_en,
    output logic       wr_en
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [7:0] STAGE_LAST  = 8'(STAGE_CYC - 1);
    localparam logic [7:0] DRAIN_LAST  = 8'(PIPE_LAT - 1);
    localparam logic [2:0] LAST_STAGE  = 3'(NUM_STAGE - 1);
    localparam logic [7:0] MULT_LAST   = 8'(MULT_CYC - 1);
    localparam logic [7:0] ADDSUB_LAST = 8'(ADDSUB_CYC - 1);
    localparam logic [7:0] MULT_RD     = 8'd128;
    localparam logic [7:0] ADDSUB_RD   = 8'd64;
    localparam logic [7:0] MULT_WR0    = 8'(MULT_CYC - 128);
    localparam logic [7:0] ADDSUB_WR0  = 8'(ADDSUB_CYC - 64);

    state_t              state;
    logic [7:0]          drain_cnt;
    logic [PIPE_LAT-1:0] rd_pipe;
    logic                ntt_mode;

    // NTT and INVNTT share the staged schedule; MULT and ADDSUB are single flat sweeps.
    assign ntt_mode = ~mode[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mode      <= 2'd0;
            stage     <= 3'd0;
            cycle_cnt <= 8'd0;
            drain_cnt <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode      <= op;
                        stage     <= 3'd0;
                        cycle_cnt <= 8'd0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (ntt_mode) begin
                        if (cycle_cnt == STAGE_LAST) begin
                            drain_cnt <= 8'd0;
                            state     <= S_DRAIN;
                        end else begin
                            cycle_cnt <= cycle_cnt + 8'd1;
                        end
                    end else if (cycle_cnt == (mode[0] ? ADDSUB_LAST : MULT_LAST)) begin
                        cycle_cnt <= 8'd0;
                        state     <= S_DONE;
                    end else begin
                        cycle_cnt <= cycle_cnt + 8'd1;
                    end
                end
                S_DRAIN: begin
                    // cycle_cnt holds while the butterfly pipeline empties.
                    if (drain_cnt == DRAIN_LAST) begin
                        cycle_cnt <= 8'd0;
                        if (stage == LAST_STAGE) begin
                            stage <= 3'd0;
                            state <= S_DONE;
                        end else begin
                            stage <= stage + 3'd1;
                            state <= S_RUN;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 8'd1;
                    end
                end
                default: begin
                    stage     <= 3'd0;
                    cycle_cnt <= 8'd0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    // Write enable for staged ops tracks the datapath: reads re-emerge PIPE_LAT cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= {rd_pipe[PIPE_LAT-2:0], rd_en & ntt_mode};
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_comb begin
        rd_en = 1'b0;
        wr_en = 1'b0;
        if (ntt_mode) begin
            rd_en = (state == S_RUN);
            wr_en = rd_pipe[PIPE_LAT-1];
        end else if (state == S_RUN) begin
            rd_en = cycle_cnt < (mode[0] ? ADDSUB_RD : MULT_RD);
            wr_en = cycle_cnt >= (mode[0] ? ADDSUB_WR0 : MULT_WR0);
        end
    end

endmodule

// File: tb/tb_poly_op_ctrl.sv
// Randomised bench for poly_op_ctrl: an offset-based schedule model checked every cycle,
// plus literal latency/enable-count expectations per operation.
module tb_poly_op_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic       busy;
    logic       done;
    logic [1:0] mode;
    logic [2:0] stage;
    logic [7:0] cycle_cnt;
    logic       rd_en;
    logic       wr_en;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    logic chk_en = 1'b0;

    // Reference: operation active flag, latched op, offset from the first RUN cycle.
    logic       m_active;
    logic [1:0] m_mode;
    int         m_t;

    poly_op_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .busy(busy), .done(done),
        .mode(mode), .stage(stage), .cycle_cnt(cycle_cnt), .rd_en(rd_en), .wr_en(wr_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int op_len(input logic [1:0] md);
        if (md < 2) return 7 * (32 + 6);
        return (md == 2) ? 140 : 68;
    endfunction

    // Expected {busy,done,mode,stage,cycle_cnt,rd_en,wr_en} from the operation offset.
    function automatic logic [16:0] expect_out(input logic act, input logic [1:0] md, input int t);
        logic       b, d, r, w;
        logic [2:0] s;
        logic [7:0] c;
        int         ph;
        b = act; d = 1'b0; r = 1'b0; w = 1'b0; s = 3'd0; c = 8'd0;
        if (act && t == op_len(md)) begin
            d = 1'b1;
        end else if (act && md < 2) begin
            ph = t % 38;
            s  = 3'(t / 38);
            r  = ph < 32;
            c  = (ph < 32) ? 8'(ph) : 8'd31;
            w  = ph >= 6;
        end else if (act) begin
            c = 8'(t);
            r = t < ((md == 2) ? 128 : 64);
            w = t >= ((md == 2) ? 12 : 4);
        end
        return {b, d, md, s, c, r, w};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_mode   <= 2'd0;
            m_t      <= 0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_mode   <= op;
                m_t      <= 0;
            end
        end else if (m_t == op_len(m_mode)) begin
            m_active <= 1'b0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (chk_en)
            check_output("outputs", 32'({busy, done, mode, stage, cycle_cnt, rd_en, wr_en}),
                         32'(expect_out(m_active, m_mode, m_t)));
    end

    // Issue one command and follow it to done; perturb toggles start/op while busy.
    task automatic apply_stimulus(input logic [1:0] o, input logic perturb);
        int s_cyc, off;
        int n_rd = 0, n_wr = 0, lat = -1;
        start = 1'b1;
        op    = o;
        s_cyc = cyc;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            off = cyc - s_cyc;
            if (rd_en) n_rd++;
            if (wr_en) n_wr++;
            if (o == 2'd0) begin
                if (off == 1)  check_output("ntt_first_rd", 32'({busy, rd_en}), 32'b11);
                if (off == 32) check_output("ntt_last_rd0", 32'(rd_en), 32'd1);
                if (off == 33) check_output("ntt_drain_rd", 32'(rd_en), 32'd0);
                if (off == 6)  check_output("ntt_wr_before", 32'(wr_en), 32'd0);
                if (off == 7)  check_output("ntt_first_wr", 32'(wr_en), 32'd1);
                if (off == 38) check_output("ntt_last_wr0", 32'(wr_en), 32'd1);
                if (off == 39) check_output("ntt_stage1", 32'({stage, rd_en, wr_en}), 32'b001_1_0);
            end
            if (done) begin
                lat = off;
                break;
            end
            start = perturb ? 1'($urandom_range(0, 1)) : 1'b0;
            if (perturb) op = 2'($urandom);
        end
        start = perturb;
        @(negedge clk);
        start = 1'b0;
        check_output("latency", 32'(lat), 32'((o < 2) ? 267 : (o == 2) ? 141 : 69));
        check_output("rd_count", 32'(n_rd), 32'((o < 2) ? 224 : (o == 2) ? 128 : 64));
        check_output("wr_count", 32'(n_wr), 32'((o < 2) ? 224 : (o == 2) ? 128 : 64));
        check_output("idle_after", 32'({busy, mode}), 32'({1'b0, o}));
    endtask

    initial begin
        int found;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (5) @(negedge clk);
        check_output("reset_idle", 32'({busy, done, mode, stage, cycle_cnt, rd_en, wr_en}), 32'd0);

        apply_stimulus(2'd0, 1'b0);
        apply_stimulus(2'd2, 1'b0);
        apply_stimulus(2'd3, 1'b0);
        apply_stimulus(2'd1, 1'b1);
        repeat (3) @(negedge clk);
        check_output("invntt_mode_held", 32'({busy, mode}), 32'b0_01);
        repeat (3) apply_stimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        // Reset in the middle of NTT stage 3 drain.
        start = 1'b1;
        op    = 2'd0;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy && stage == 3'd3 && !rd_en) begin
                found = 1;
                break;
            end
        end
        check_output("drain_reached", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("mid_reset", 32'({busy, done, mode, stage, cycle_cnt, rd_en, wr_en}), 32'd0);
        found = 0;
        repeat (8) begin
            @(negedge clk);
            if (wr_en) found++;
        end
        check_output("no_stray_wr", 32'(found), 32'd0);
        apply_stimulus(2'd3, 1'b0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
